glitch_sweep_ctrl: RTL
======================

GLITCH_SWEEP_CTRL -- requirements
Module: glitch_sweep_ctrl

Interface
REQ-001 Parameter CW, default 32: width of the delay and width configuration words.
REQ-002 Parameter DELAY_MIN / DELAY_MAX / DELAY_STEP, defaults 300 / 600 / 10: delay sweep bounds and increment, in PLL clock cycles.
REQ-003 Parameter WIDTH_MIN / WIDTH_MAX / WIDTH_STEP, defaults 300 / 600 / 50: pulse-width sweep bounds and increment, in PLL clock cycles.
REQ-004 CLK  in  1  single clock (300 MHz PLL output); all logic SHALL be on its rising edge.
REQ-005 RSTN  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a campaign.
REQ-007 abort  in  1  level input that ends a campaign immediately.
REQ-008 eng_ack  in  1  one-cycle pulse from the glitch engine: arm accepted.
REQ-009 eng_done  in  1  one-cycle pulse from the engine: glitch attempt finished.
REQ-010 arm  out  1  request to the engine to run one attempt with the current configuration.
REQ-011 delay_cfg  out  CW  delay count presented to the engine.
REQ-012 width_cfg  out  CW  pulse-width count presented to the engine.
REQ-013 active  out  1  high while a campaign is in progress.
REQ-014 campaign_done  out  1  one-cycle pulse when the full sweep completes.
REQ-015 aborted  out  1  one-cycle pulse when a campaign is aborted.
REQ-016 attempt_count  out  16  number of completed attempts in the current or last campaign.

Function
REQ-017 States SHALL be IDLE, LOAD, ARM, WAIT_DONE, STEP and FINISH.
REQ-018 IDLE: on start=1 with abort=0, the block SHALL load delay_cfg=DELAY_MIN, width_cfg=WIDTH_MIN and attempt_count=0, then go to LOAD.
REQ-019 LOAD: the block SHALL spend one cycle here, then go to ARM, so the configuration is stable at least one cycle before arm rises.
REQ-020 ARM: arm SHALL be 1 and held until eng_ack=1; on the ack cycle the block SHALL go to WAIT_DONE, with arm=0 from the next cycle.
REQ-021 ARM, with eng_ack and eng_done in the same cycle: the block SHALL count the attempt as complete and go directly to STEP.
REQ-022 eng_done SHALL be ignored in every state except WAIT_DONE and the REQ-021 case; eng_ack SHALL be ignored outside ARM.
REQ-023 WAIT_DONE: on eng_done, attempt_count SHALL increment, saturating at 0xFFFF, and the block SHALL go to STEP.
REQ-024 STEP, when delay_cfg+DELAY_STEP <= DELAY_MAX: delay_cfg SHALL advance by DELAY_STEP, and the next state SHALL be LOAD.
REQ-025 STEP, delay overflow with width_cfg+WIDTH_STEP <= WIDTH_MAX: delay_cfg SHALL wrap to DELAY_MIN, width_cfg SHALL advance by WIDTH_STEP, and the next state SHALL be LOAD.
REQ-026 STEP, both delay and width exceeding their maxima: the next state SHALL be FINISH.
REQ-027 The sums in REQ-024 to REQ-026 SHALL be evaluated at CW+1 bits, so a sum that overflows CW bits counts as exceeding the maximum.
REQ-028 FINISH: campaign_done SHALL pulse for one cycle and the block SHALL return to IDLE.
REQ-029 abort=1 in any state other than IDLE SHALL, in the next cycle, force IDLE, arm=0 and a one-cycle aborted pulse.
REQ-030 abort SHALL take priority over all other transitions, including start in IDLE.
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 active SHALL be 1 in every state except IDLE.
REQ-033 delay_cfg, width_cfg and attempt_count SHALL hold their values in IDLE after a campaign ends.
REQ-034 delay_cfg and width_cfg SHALL change only on the IDLE->LOAD transition and in STEP.
REQ-035 With DELAY_MIN=DELAY_MAX and WIDTH_MIN=WIDTH_MAX, the block SHALL run exactly one attempt.

Reset
REQ-036 RSTN=0 SHALL asynchronously force IDLE, arm=0, active=0, campaign_done=0, aborted=0, delay_cfg=0, width_cfg=0 and attempt_count=0.
REQ-037 Reset asserted mid-campaign SHALL abandon the campaign without an aborted pulse.
REQ-038 After reset deassertion, the block SHALL require a new start pulse.

Structure
REQ-039 The state encoding localparams and the CW default SHALL reside in the shared glitch_pkg definitions, alongside the glitch engine's state constants.
REQ-040 The next-value and overflow computation SHALL be a combinational sub-module, glitch_param_stepper, instantiated once.

Verification
REQ-041 Bench parameters for REQ-042 to REQ-046: DELAY 300/320/10, WIDTH 300/350/50.
REQ-042 Full sweep: start, with an engine model that acks after 2 cycles and signals done after 5 -> attempts run (300,300) (310,300) (320,300) (300,350) (310,350) (320,350), then campaign_done, attempt_count=6.
REQ-043 Arm handshake: eng_ack delayed 20 cycles -> arm held for those 20 cycles, and delay_cfg/width_cfg stable throughout arm.
REQ-044 Abort: abort during the 3rd WAIT_DONE -> IDLE next cycle, aborted pulse, attempt_count=2, then a later eng_done is ignored.
REQ-045 Coincident and stray engine pulses: eng_ack and eng_done in the same cycle -> STEP with attempt_count incremented; start while active -> ignored.
REQ-046 Async reset: RSTN=0 mid-ARM, not aligned to a clock edge -> outputs zero immediately, no aborted pulse, and start is required to restart.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch subsystem: sweep controller state
// encoding, engine state constants, default word widths and a saturating
// counter helper.
package glitch_pkg;

   // Default width of the delay / pulse-width configuration words
   localparam int unsigned CW_DEFAULT = 32;

   // Width of the completed-attempt counter
   localparam int unsigned CNT_W = 16;

   // Sweep controller state encoding
   localparam logic [2:0] SWEEP_IDLE      = 3'd0;
   localparam logic [2:0] SWEEP_LOAD      = 3'd1;
   localparam logic [2:0] SWEEP_ARM       = 3'd2;
   localparam logic [2:0] SWEEP_WAIT_DONE = 3'd3;
   localparam logic [2:0] SWEEP_STEP      = 3'd4;
   localparam logic [2:0] SWEEP_FINISH    = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE      = SWEEP_IDLE,
      ST_LOAD      = SWEEP_LOAD,
      ST_ARM       = SWEEP_ARM,
      ST_WAIT_DONE = SWEEP_WAIT_DONE,
      ST_STEP      = SWEEP_STEP,
      ST_FINISH    = SWEEP_FINISH
   } sweep_state_t;

   // Glitch engine state constants (engine lives in its own block)
   localparam logic [1:0] ENG_IDLE  = 2'd0;
   localparam logic [1:0] ENG_DELAY = 2'd1;
   localparam logic [1:0] ENG_PULSE = 2'd2;
   localparam logic [1:0] ENG_DONE  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Increment that sticks at all-ones instead of wrapping to zero
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (value == CNT_MAX) begin
         result = value;
      end else begin
         result = value + CNT_ONE;
      end
      return result;
   endfunction

endpackage

// File: rtl/glitch_param_stepper.sv
// glitch_param_stepper: combinational next-point calculator for the
// (delay, width) sweep grid. Delay is the inner loop, width the outer one.
// Sums are formed one bit wider than the configuration words so that a
// carry out of CW bits is treated as running past the maximum.
module glitch_param_stepper
   import glitch_pkg::*;
#(
   parameter int unsigned CW         = CW_DEFAULT,
   parameter int unsigned DELAY_MIN  = 300,
   parameter int unsigned DELAY_MAX  = 600,
   parameter int unsigned DELAY_STEP = 10,
   parameter int unsigned WIDTH_MAX  = 600,
   parameter int unsigned WIDTH_STEP = 50
) (
   input  logic [CW-1:0] delay_cur,
   input  logic [CW-1:0] width_cur,
   output logic [CW-1:0] delay_next,
   output logic [CW-1:0] width_next,
   output logic          sweep_end
);

   localparam logic [CW:0]   DELAY_STEP_W = (CW+1)'(DELAY_STEP);
   localparam logic [CW:0]   DELAY_MAX_W  = (CW+1)'(DELAY_MAX);
   localparam logic [CW:0]   WIDTH_STEP_W = (CW+1)'(WIDTH_STEP);
   localparam logic [CW:0]   WIDTH_MAX_W  = (CW+1)'(WIDTH_MAX);
   localparam logic [CW-1:0] DELAY_RESTART = CW'(DELAY_MIN);

   logic [CW:0] delay_sum_s;
   logic [CW:0] width_sum_s;
   logic        delay_fits_s;
   logic        width_fits_s;

   // Widened candidate sums and their range checks
   always_comb begin
      delay_sum_s  = {1'b0, delay_cur} + DELAY_STEP_W;
      width_sum_s  = {1'b0, width_cur} + WIDTH_STEP_W;
      delay_fits_s = (delay_sum_s <= DELAY_MAX_W);
      width_fits_s = (width_sum_s <= WIDTH_MAX_W);
   end

   // Pick the next grid point: advance delay, else wrap delay and advance width, else end
   always_comb begin
      delay_next = delay_cur;
      width_next = width_cur;
      sweep_end  = 1'b0;
      if (delay_fits_s) begin
         delay_next = delay_sum_s[CW-1:0];
         width_next = width_cur;
         sweep_end  = 1'b0;
      end else if (width_fits_s) begin
         delay_next = DELAY_RESTART;
         width_next = width_sum_s[CW-1:0];
         sweep_end  = 1'b0;
      end else begin
         delay_next = delay_cur;
         width_next = width_cur;
         sweep_end  = 1'b1;
      end
   end

endmodule

// File: rtl/glitch_sweep_ctrl.sv
// glitch_sweep_ctrl: walks the (delay, width) grid one point at a time,
// arming the glitch engine for each point and counting completed attempts.
// All outputs are registered; abort preempts every transition once a
// campaign is running.
module glitch_sweep_ctrl
   import glitch_pkg::*;
#(
   parameter int unsigned CW         = CW_DEFAULT,
   parameter int unsigned DELAY_MIN  = 300,
   parameter int unsigned DELAY_MAX  = 600,
   parameter int unsigned DELAY_STEP = 10,
   parameter int unsigned WIDTH_MIN  = 300,
   parameter int unsigned WIDTH_MAX  = 600,
   parameter int unsigned WIDTH_STEP = 50
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             start,
   input  logic             abort,
   input  logic             eng_ack,
   input  logic             eng_done,
   output logic             arm,
   output logic [CW-1:0]    delay_cfg,
   output logic [CW-1:0]    width_cfg,
   output logic             active,
   output logic             campaign_done,
   output logic             aborted,
   output logic [CNT_W-1:0] attempt_count
);

   localparam logic [CW-1:0] DELAY_FIRST = CW'(DELAY_MIN);
   localparam logic [CW-1:0] WIDTH_FIRST = CW'(WIDTH_MIN);

   sweep_state_t     state_r;
   logic             arm_r;
   logic [CW-1:0]    delay_r;
   logic [CW-1:0]    width_r;
   logic             active_r;
   logic             campaign_done_r;
   logic             aborted_r;
   logic [CNT_W-1:0] count_r;

   logic [CW-1:0]    delay_next_s;
   logic [CW-1:0]    width_next_s;
   logic             sweep_end_s;

   glitch_param_stepper #(
      .CW         (CW),
      .DELAY_MIN  (DELAY_MIN),
      .DELAY_MAX  (DELAY_MAX),
      .DELAY_STEP (DELAY_STEP),
      .WIDTH_MAX  (WIDTH_MAX),
      .WIDTH_STEP (WIDTH_STEP)
   ) u_stepper (
      .delay_cur  (delay_r),
      .width_cur  (width_r),
      .delay_next (delay_next_s),
      .width_next (width_next_s),
      .sweep_end  (sweep_end_s)
   );

   // Sweep state machine with registered handshake, status and configuration outputs
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_r         <= ST_IDLE;
         arm_r           <= 1'b0;
         delay_r         <= '0;
         width_r         <= '0;
         active_r        <= 1'b0;
         campaign_done_r <= 1'b0;
         aborted_r       <= 1'b0;
         count_r         <= '0;
      end else begin
         // Status pulses last exactly one cycle unless re-raised below
         campaign_done_r <= 1'b0;
         aborted_r       <= 1'b0;
         if (abort && (state_r != ST_IDLE)) begin
            state_r   <= ST_IDLE;
            arm_r     <= 1'b0;
            active_r  <= 1'b0;
            aborted_r <= 1'b1;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  // abort already excluded above only for non-idle states
                  if (start && !abort) begin
                     delay_r  <= DELAY_FIRST;
                     width_r  <= WIDTH_FIRST;
                     count_r  <= '0;
                     active_r <= 1'b1;
                     state_r  <= ST_LOAD;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               ST_LOAD: begin
                  // Configuration has been stable for a full cycle; raise arm
                  arm_r   <= 1'b1;
                  state_r <= ST_ARM;
               end
               ST_ARM: begin
                  if (eng_ack) begin
                     arm_r <= 1'b0;
                     if (eng_done) begin
                        count_r <= sat_inc(count_r);
                        state_r <= ST_STEP;
                     end else begin
                        state_r <= ST_WAIT_DONE;
                     end
                  end else begin
                     state_r <= ST_ARM;
                  end
               end
               ST_WAIT_DONE: begin
                  if (eng_done) begin
                     count_r <= sat_inc(count_r);
                     state_r <= ST_STEP;
                  end else begin
                     state_r <= ST_WAIT_DONE;
                  end
               end
               ST_STEP: begin
                  if (sweep_end_s) begin
                     campaign_done_r <= 1'b1;
                     state_r         <= ST_FINISH;
                  end else begin
                     delay_r <= delay_next_s;
                     width_r <= width_next_s;
                     state_r <= ST_LOAD;
                  end
               end
               ST_FINISH: begin
                  active_r <= 1'b0;
                  state_r  <= ST_IDLE;
               end
               default: begin
                  arm_r    <= 1'b0;
                  active_r <= 1'b0;
                  state_r  <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign arm           = arm_r;
   assign delay_cfg     = delay_r;
   assign width_cfg     = width_r;
   assign active        = active_r;
   assign campaign_done = campaign_done_r;
   assign aborted       = aborted_r;
   assign attempt_count = count_r;

endmodule
